fanout_tap_checker: RTL and testbench

- Sequential monitor on the downstream side of a buffered fanout net: one driver net plus NUM_TAPS load-side taps, each reached through inserted buffers and possibly across hierarchy.
- Samples the driver and every tap over a programmable window and flags taps whose value disagrees with the driver.
- Counts mismatches per window and reports which taps failed.
- Used in buffer-insertion regression designs to prove that buffering preserved the driver value at every load.

---
 rtl/fanout_tap_pkg.sv | 20 ++
 rtl/fanout_tap_sync.sv | 25 ++
 rtl/fanout_tap_checker.sv | 109 ++++++++++
 tb/tb_fanout_tap_checker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/fanout_tap_pkg.sv
// Shared types, default widths and arithmetic helpers for the fanout tap checker.
package fanout_tap_pkg;

   typedef enum logic [1:0] {IDLE, ALIGN, SAMPLE, REPORT} state_e;

   localparam int NUM_TAPS_D    = 3;
   localparam int SYNC_STAGES_D = 2;
   localparam int WIN_W_D       = 8;
   localparam int CNT_W_D       = 8;

   // Add two unsigned values and clamp the result at max_v.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_v);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
   endfunction

endpackage

// File: rtl/fanout_tap_sync.sv
// Fixed-depth flop pipe. The driver and the taps both pass through one, so they stay cycle-aligned.
module fanout_tap_sync #(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] pipe;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pipe <= '0;
      end else begin
         pipe[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign q = pipe[SYNC_STAGES-1];

endmodule

// File: rtl/fanout_tap_checker.sv
// Compares each buffered fanout tap against its driver over a programmable window.
// Defining FANOUT_TAP_FIRST_FAIL_EN adds the first-mismatch index outputs.
module fanout_tap_checker
   import fanout_tap_pkg::*;
#(
   parameter int NUM_TAPS    = NUM_TAPS_D,
   parameter int SYNC_STAGES = SYNC_STAGES_D,
   parameter int WIN_W       = WIN_W_D,
   parameter int CNT_W       = CNT_W_D
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                drvr_i,
   input  logic [NUM_TAPS-1:0] tap_i,
   input  logic                start_i,
   input  logic [WIN_W-1:0]    win_len_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [CNT_W-1:0]    mismatch_cnt_o,
   output logic [NUM_TAPS-1:0] fail_mask_o,
   output logic                err_o
`ifdef FANOUT_TAP_FIRST_FAIL_EN
   ,
   output logic [WIN_W-1:0]    first_fail_idx_o,
   output logic                first_fail_vld_o
`endif
);

   state_e              state, state_nxt;
   logic [WIN_W-1:0]    cnt_q;
   logic [WIN_W-1:0]    win_len_q;
   logic                drvr_sync;
   logic [NUM_TAPS-1:0] tap_sync;
   logic [NUM_TAPS-1:0] cmp;

   fanout_tap_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_drvr (
      .clk(clk), .rst_n(rst_n), .d(drvr_i), .q(drvr_sync)
   );

   fanout_tap_sync #(.WIDTH(NUM_TAPS), .SYNC_STAGES(SYNC_STAGES)) u_sync_tap (
      .clk(clk), .rst_n(rst_n), .d(tap_i), .q(tap_sync)
   );

   assign cmp = tap_sync ^ {NUM_TAPS{drvr_sync}};

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = ALIGN;
         ALIGN:   if (cnt_q == WIN_W'(SYNC_STAGES - 1))
                     state_nxt = (win_len_q == '0) ? REPORT : SAMPLE;
         SAMPLE:  if (cnt_q == win_len_q - WIN_W'(1)) state_nxt = REPORT;
         REPORT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cnt_q counts the flush cycles in ALIGN, then doubles as the SAMPLE index.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt_q          <= '0;
         win_len_q      <= '0;
         mismatch_cnt_o <= '0;
         fail_mask_o    <= '0;
         err_o          <= 1'b0;
`ifdef FANOUT_TAP_FIRST_FAIL_EN
         first_fail_idx_o <= '0;
         first_fail_vld_o <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (start_i) begin
               win_len_q      <= win_len_i;
               cnt_q          <= '0;
               mismatch_cnt_o <= '0;
               fail_mask_o    <= '0;
               err_o          <= 1'b0;
`ifdef FANOUT_TAP_FIRST_FAIL_EN
               first_fail_idx_o <= '0;
               first_fail_vld_o <= 1'b0;
`endif
            end
            ALIGN: cnt_q <= (state_nxt != ALIGN) ? '0 : cnt_q + WIN_W'(1);
            SAMPLE: begin
               cnt_q          <= cnt_q + WIN_W'(1);
               mismatch_cnt_o <= CNT_W'(sat_add(32'(mismatch_cnt_o),
                                                32'($countones(cmp)),
                                                32'({CNT_W{1'b1}})));
               fail_mask_o    <= fail_mask_o | cmp;
               // err_o must be valid in the same cycle done_o rises, so fold in the last compare here.
               if (state_nxt == REPORT) err_o <= |(fail_mask_o | cmp);
`ifdef FANOUT_TAP_FIRST_FAIL_EN
               if (!first_fail_vld_o && (|cmp)) begin
                  first_fail_idx_o <= cnt_q;
                  first_fail_vld_o <= 1'b1;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign busy_o = (state == ALIGN) || (state == SAMPLE);
   assign done_o = (state == REPORT);

endmodule

// File: tb/tb_fanout_tap_checker.sv
// Scoreboard bench: each window pushes its expected result, and a done_o monitor pops and checks it.
module tb_fanout_tap_checker;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       drvr_i;
   logic [2:0] tap_i;
   logic       start_i;
   logic [7:0] win_len_i;
   logic       busy_o, done_o, err_o;
   logic [7:0] mismatch_cnt_o;
   logic [2:0] fail_mask_o;
`ifdef FANOUT_TAP_FIRST_FAIL_EN
   logic [7:0] first_fail_idx_o;
   logic       first_fail_vld_o;
`endif

   typedef struct {
      logic [7:0] cnt;
      logic [2:0] mask;
      logic       err;
      int         lat;
      int         start_cyc;
      logic [7:0] ffi;
      logic       ffv;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   asserts = 0;
   int   fails = 0;

   fanout_tap_checker dut (
      .clk(clk), .rst_n(rst_n), .drvr_i(drvr_i), .tap_i(tap_i),
      .start_i(start_i), .win_len_i(win_len_i), .busy_o(busy_o),
      .done_o(done_o), .mismatch_cnt_o(mismatch_cnt_o),
      .fail_mask_o(fail_mask_o), .err_o(err_o)
`ifdef FANOUT_TAP_FIRST_FAIL_EN
      , .first_fail_idx_o(first_fail_idx_o), .first_fail_vld_o(first_fail_vld_o)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every done_o pulse must match the oldest outstanding window.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done_o === 1'b1) begin
         if (sb.size() == 0) begin
            asserts++;
            fails++;
            $display("FAIL unexpected_done: got done_o=1 expected no done (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
            chk("mismatch_cnt", 32'(mismatch_cnt_o), 32'(e.cnt));
            chk("fail_mask", 32'(fail_mask_o), 32'(e.mask));
            chk("err", 32'(err_o), 32'(e.err));
            chk("busy_in_report", 32'(busy_o), 32'd0);
`ifdef FANOUT_TAP_FIRST_FAIL_EN
            chk("first_fail_vld", 32'(first_fail_vld_o), 32'(e.ffv));
            if (e.ffv) chk("first_fail_idx", 32'(first_fail_idx_o), 32'(e.ffi));
`endif
         end
      end
   end

   task automatic drive(input int mode, input int j);
      case (mode)
         0: begin drvr_i = (j % 2 == 1); tap_i = {3{drvr_i}}; end
         1: begin drvr_i = 1'b1; tap_i = 3'b101; end
         2: begin drvr_i = 1'b0; tap_i = 3'b111; end
         default: begin
            drvr_i = (j % 2 == 1);
            tap_i  = {3{drvr_i}};
            if (j == 5) tap_i[2] = ~tap_i[2];
         end
      endcase
   endtask

   // Issue one window and keep driving data long enough for done_o to appear.
   task automatic run_win(input int win, input int mode, input exp_t e, input bit dbl);
      e.start_cyc = cyc;
      e.lat       = 3 + win;
      sb.push_back(e);
      for (int j = 0; j < win + 7; j++) begin
         drive(mode, j);
         start_i   = (j == 0) || (dbl && j == 2);
         win_len_i = (j == 2 && dbl) ? 8'd50 : 8'(win);
         if (dbl && j == 2) chk("busy_during_ignored_start", 32'(busy_o), 32'd1);
         @(negedge clk);
      end
      start_i = 1'b0;
      asserts++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL done_timeout: got no done_o expected one within %0d cycles", win + 7);
         sb.delete();
      end
      chk("result_hold", 32'(mismatch_cnt_o), 32'(e.cnt));
   endtask

   function automatic exp_t mk(input logic [7:0] cnt, input logic [2:0] mask,
                               input logic ffv, input logic [7:0] ffi);
      exp_t e;
      e.cnt = cnt; e.mask = mask; e.err = |mask;
      e.ffv = ffv; e.ffi = ffi; e.lat = 0; e.start_cyc = 0;
      return e;
   endfunction

   initial begin
      rst_n = 1'b0; drvr_i = 1'b0; tap_i = '0; start_i = 1'b0; win_len_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_cnt", 32'(mismatch_cnt_o), 32'd0);
      chk("rst_mask", 32'(fail_mask_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_busy", 32'(busy_o), 32'd0);

      run_win(10,  0, mk(8'd0,   3'b000, 1'b0, 8'd0), 1'b0);
      run_win(5,   1, mk(8'd5,   3'b010, 1'b1, 8'd0), 1'b0);
      run_win(200, 2, mk(8'd255, 3'b111, 1'b1, 8'd0), 1'b0);
      run_win(0,   1, mk(8'd0,   3'b000, 1'b0, 8'd0), 1'b0);
      run_win(6,   1, mk(8'd6,   3'b010, 1'b1, 8'd0), 1'b1);
      run_win(8,   3, mk(8'd1,   3'b100, 1'b1, 8'd4), 1'b0);

      // Reset in the middle of SAMPLE: window is abandoned and nothing reports.
      drive(1, 0);
      start_i = 1'b1; win_len_i = 8'd20;
      @(negedge clk);
      start_i = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_busy_before_rst", 32'(busy_o), 32'd1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_cnt", 32'(mismatch_cnt_o), 32'd0);
      chk("mid_rst_mask", 32'(fail_mask_o), 32'd0);
      chk("mid_rst_err", 32'(err_o), 32'd0);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      chk("mid_rst_idle_busy", 32'(busy_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
